rec_fn_to_fn_pipe: RTL and testbench

REC_FN_TO_FN_PIPE -- requirements
Module: rec_fn_to_fn_pipe

---
 rtl/rec_fn_to_fn_pipe_pkg.sv | 36 +++
 rtl/rec_fn_unpack.sv | 32 +++
 rtl/rec_fn_to_fn_pipe.sv | 134 +++++++++++++
 tb/tb_rec_fn_to_fn_pipe.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/rec_fn_to_fn_pipe_pkg.sv
// rec_fn_to_fn_pipe_pkg: shared widths, special exponent codes and raw-float type
// for the recoded binary32 to IEEE binary32 pipeline. Rev 1.0
`default_nettype none

package rec_fn_to_fn_pipe_pkg;

  localparam int EXP_WIDTH     = 8;
  localparam int SIG_WIDTH     = 24;
  localparam int REC_WIDTH     = EXP_WIDTH + SIG_WIDTH + 1;  // 33
  localparam int OUT_WIDTH     = EXP_WIDTH + SIG_WIDTH;      // 32
  localparam int REC_EXP_WIDTH = EXP_WIDTH + 1;              // 9
  localparam int SEXP_WIDTH    = EXP_WIDTH + 2;              // 10
  localparam int RAW_SIG_WIDTH = SIG_WIDTH + 1;              // 25
  localparam int FRACT_WIDTH   = SIG_WIDTH - 1;              // 23
  localparam int SHIFT_WIDTH   = 5;
  localparam int CLASS_WIDTH   = 10;

  localparam logic [SEXP_WIDTH-1:0] MIN_NORM_EXP = 10'd130;
  localparam logic [EXP_WIDTH-1:0]  BIAS_OFFSET  = 8'd129;

  localparam logic [2:0] CODE_ZERO = 3'b000;
  localparam logic [2:0] CODE_INF  = 3'b110;
  localparam logic [2:0] CODE_NAN  = 3'b111;

  typedef struct packed {
    logic                     is_nan;
    logic                     is_inf;
    logic                     is_zero;
    logic                     sign;
    logic [SEXP_WIDTH-1:0]    sexp;
    logic [RAW_SIG_WIDTH-1:0] sig;
  } raw_float_t;

endpackage

`default_nettype wire

// File: rtl/rec_fn_unpack.sv
// rec_fn_unpack: combinational split of a recoded binary32 word into raw fields.
// Rev 1.0
`default_nettype none

module rec_fn_unpack
  import rec_fn_to_fn_pipe_pkg::*;
(
  input  logic [REC_WIDTH-1:0] rec_in,
  output raw_float_t           raw_out
);

  logic [REC_EXP_WIDTH-1:0] rec_exp;
  logic [FRACT_WIDTH-1:0]   rec_fract;
  logic                     is_zero;

  assign rec_exp   = rec_in[REC_WIDTH-2 -: REC_EXP_WIDTH];
  assign rec_fract = rec_in[FRACT_WIDTH-1:0];
  assign is_zero   = (rec_exp[REC_EXP_WIDTH-1 -: 3] == CODE_ZERO);

  always_comb begin
    raw_out         = '0;
    raw_out.sign    = rec_in[REC_WIDTH-1];
    raw_out.is_zero = is_zero;
    raw_out.is_inf  = (rec_exp[REC_EXP_WIDTH-1 -: 3] == CODE_INF);
    raw_out.is_nan  = (rec_exp[REC_EXP_WIDTH-1 -: 3] == CODE_NAN);
    raw_out.sexp    = {1'b0, rec_exp};
    raw_out.sig     = {1'b0, !is_zero, rec_fract};
  end

endmodule

`default_nettype wire

// File: rtl/rec_fn_to_fn_pipe.sv
// rec_fn_to_fn_pipe: 2-stage valid/ready converter, recoded binary32 -> IEEE binary32.
// Define RECFN_CLASSIFY_EN to add the registered RISC-V fclass output. Rev 1.0
`default_nettype none

module rec_fn_to_fn_pipe
  import rec_fn_to_fn_pipe_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_in_valid,
  output logic                   io_in_ready,
  input  logic [REC_WIDTH-1:0]   io_in_bits,
  output logic                   io_out_valid,
  input  logic                   io_out_ready,
  output logic [OUT_WIDTH-1:0]   io_out_bits,
  output logic                   io_out_isSigNaN
`ifdef RECFN_CLASSIFY_EN
  ,
  output logic [CLASS_WIDTH-1:0] io_out_classify
`endif
);

  raw_float_t unpacked;
  raw_float_t s1_q;
  logic       s1_valid;
  logic       s2_valid;
  logic       s2_ready;

  logic [OUT_WIDTH-1:0]     s2_bits;
  logic                     s2_sig_nan;
  logic                     is_sub;
  logic [SHIFT_WIDTH-1:0]   shift;
  logic [RAW_SIG_WIDTH-1:0] sig_half;
  logic [FRACT_WIDTH-1:0]   denorm_fract;
  logic [FRACT_WIDTH-1:0]   fract_out;
  logic [EXP_WIDTH-1:0]     exp_out;
  logic                     sig_nan;

  rec_fn_unpack u_unpack (
    .rec_in  (io_in_bits),
    .raw_out (unpacked)
  );

  // S1 may refill in the same cycle S2 drains, so throughput stays one word per cycle.
  assign s2_ready    = !s2_valid || io_out_ready;
  assign io_in_ready = !s1_valid || s2_ready;

  assign sig_half = s1_q.sig >> 1;

  always_comb begin
    is_sub       = (s1_q.sexp < MIN_NORM_EXP);
    shift        = 5'd1 - s1_q.sexp[SHIFT_WIDTH-1:0];
    denorm_fract = FRACT_WIDTH'(sig_half >> shift);
    exp_out      = s1_q.sexp[EXP_WIDTH-1:0] - BIAS_OFFSET;
    fract_out    = s1_q.sig[FRACT_WIDTH-1:0];
    if (is_sub) begin
      exp_out   = '0;
      fract_out = denorm_fract;
    end else if (s1_q.is_inf) begin
      fract_out = '0;
    end
    if (s1_q.is_nan || s1_q.is_inf) begin
      exp_out = '1;
    end
    sig_nan = s1_q.is_nan && !s1_q.sig[FRACT_WIDTH-1];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_valid   <= 1'b0;
      s1_q       <= '0;
      s2_valid   <= 1'b0;
      s2_bits    <= '0;
      s2_sig_nan <= 1'b0;
    end else begin
      if (io_in_ready) begin
        s1_valid <= io_in_valid;
        if (io_in_valid) begin
          s1_q <= unpacked;
        end
      end
      if (s2_ready) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_bits    <= {s1_q.sign, exp_out, fract_out};
          s2_sig_nan <= sig_nan;
        end
      end
    end
  end

  assign io_out_valid    = s2_valid;
  assign io_out_bits     = s2_bits;
  assign io_out_isSigNaN = s2_sig_nan;

`ifdef RECFN_CLASSIFY_EN
  // Bit order: -inf,-norm,-sub,-0,+0,+sub,+norm,+inf,sNaN,qNaN (bit 0 first).
  logic [CLASS_WIDTH-1:0] cls;
  logic [CLASS_WIDTH-1:0] s2_class;

  always_comb begin
    cls = '0;
    if (s1_q.is_nan) begin
      cls[8] = sig_nan;
      cls[9] = !sig_nan;
    end else if (s1_q.is_inf) begin
      cls[0] = s1_q.sign;
      cls[7] = !s1_q.sign;
    end else if (s1_q.is_zero) begin
      cls[3] = s1_q.sign;
      cls[4] = !s1_q.sign;
    end else if (is_sub) begin
      cls[2] = s1_q.sign;
      cls[5] = !s1_q.sign;
    end else begin
      cls[1] = s1_q.sign;
      cls[6] = !s1_q.sign;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      s2_class <= '0;
    end else if (s2_ready && s1_valid) begin
      s2_class <= cls;
    end
  end

  assign io_out_classify = s2_class;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rec_fn_to_fn_pipe.sv
// tb_rec_fn_to_fn_pipe: directed-vector self-checking bench for rec_fn_to_fn_pipe.
// Rev 1.0
`default_nettype none

module tb_rec_fn_to_fn_pipe;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_in_valid = 1'b0;
  logic        io_in_ready;
  logic [32:0] io_in_bits = '0;
  logic        io_out_valid;
  logic        io_out_ready = 1'b0;
  logic [31:0] io_out_bits;
  logic        io_out_isSigNaN;
`ifdef RECFN_CLASSIFY_EN
  logic [9:0]  io_out_classify;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  rec_fn_to_fn_pipe dut (
    .clock           (clock),
    .reset           (reset),
    .io_in_valid     (io_in_valid),
    .io_in_ready     (io_in_ready),
    .io_in_bits      (io_in_bits),
    .io_out_valid    (io_out_valid),
    .io_out_ready    (io_out_ready),
    .io_out_bits     (io_out_bits),
    .io_out_isSigNaN (io_out_isSigNaN)
`ifdef RECFN_CLASSIFY_EN
    ,
    .io_out_classify (io_out_classify)
`endif
  );

  always #5 clock = ~clock;

  // Hand-computed vectors: recoded input, IEEE output, signalling-NaN flag, fclass.
  logic [32:0] vin [12] = '{
    33'h080000000, 33'h000000000, 33'h100000000, 33'h0C0000000,
    33'h0E0400000, 33'h0E0000001, 33'h035800000, 33'h040800000,
    33'h040400000, 33'h180800000, 33'h0BFFFFFFF, 33'h135800000};
  logic [31:0] vout [12] = '{
    32'h3F800000, 32'h00000000, 32'h80000000, 32'h7F800000,
    32'h7FC00000, 32'h7F800001, 32'h00000001, 32'h00400000,
    32'h00300000, 32'hC0000000, 32'h7F7FFFFF, 32'h80000001};
  logic        vsnan [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [9:0]  vcls [12] = '{
    10'h040, 10'h010, 10'h008, 10'h080, 10'h200, 10'h100,
    10'h020, 10'h020, 10'h020, 10'h002, 10'h040, 10'h004};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_word(input string tag, input int i);
    check({tag, "_bits"}, io_out_bits, vout[i]);
    check({tag, "_signan"}, io_out_isSigNaN, vsnan[i]);
`ifdef RECFN_CLASSIFY_EN
    check({tag, "_class"}, io_out_classify, vcls[i]);
`endif
  endtask

  // One isolated word: invisible after one edge, present after exactly two.
  task automatic send_one(input int i);
    @(negedge clock);
    io_out_ready = 1'b1;
    io_in_valid  = 1'b1;
    io_in_bits   = vin[i];
    @(posedge clock);
    @(negedge clock);
    io_in_valid = 1'b0;
    check($sformatf("v%0d_lat1_valid", i), io_out_valid, 1'b0);
    @(posedge clock);
    @(negedge clock);
    check($sformatf("v%0d_valid", i), io_out_valid, 1'b1);
    check_word($sformatf("v%0d", i), i);
  endtask

  task automatic stream_test();
    int q[$];
    int sent = 0;
    int got = 0;
    int occ = 0;
    int cyc = 0;
    logic        hold = 1'b0;
    logic [31:0] held = '0;
    while (got < 8 && cyc < 200) begin
      @(negedge clock);
      io_out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      io_in_valid  = (sent < 8);
      io_in_bits   = (sent < 8) ? vin[sent] : '0;
      #1;
      check($sformatf("s%0d_in_ready", cyc), io_in_ready, (occ < 2) || io_out_ready);
      if (hold) begin
        check($sformatf("s%0d_hold", cyc), io_out_bits, held);
      end
      if (io_out_valid && io_out_ready) begin
        if (q.size() == 0) begin
          check($sformatf("s%0d_extra_word", cyc), 1'b1, 1'b0);
        end else begin
          check_word($sformatf("s%0d_out", cyc), q.pop_front());
        end
        got++;
        occ--;
      end
      hold = io_out_valid && !io_out_ready;
      held = io_out_bits;
      if (io_in_valid && io_in_ready) begin
        q.push_back(sent);
        sent++;
        occ++;
      end
      cyc++;
    end
    check("stream_count", got, 8);
    @(negedge clock);
    io_in_valid  = 1'b0;
    io_out_ready = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("stream_no_dup", io_out_valid, 1'b0);
    end
  endtask

  task automatic reset_midflight();
    @(negedge clock);
    io_out_ready = 1'b0;
    io_in_valid  = 1'b1;
    io_in_bits   = vin[3];
    @(negedge clock);
    io_in_bits   = vin[4];
    @(negedge clock);
    io_in_valid  = 1'b0;
    #1;
    check("full_in_ready", io_in_ready, 1'b0);
    check("full_out_valid", io_out_valid, 1'b1);
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_out_valid", io_out_valid, 1'b0);
    check("mid_rst_in_ready", io_in_ready, 1'b1);
    check("mid_rst_bits", io_out_bits, 32'h0);
    reset        = 1'b1;
    io_out_ready = 1'b1;
    repeat (4) begin
      @(negedge clock);
      check("post_rst_no_stale", io_out_valid, 1'b0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("rst_out_valid", io_out_valid, 1'b0);
    check("rst_in_ready", io_in_ready, 1'b1);
    check("rst_bits", io_out_bits, 32'h0);
    check("rst_signan", io_out_isSigNaN, 1'b0);
`ifdef RECFN_CLASSIFY_EN
    check("rst_class", io_out_classify, 10'h0);
`endif
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      send_one(i);
    end

    stream_test();
    reset_midflight();
    send_one(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
